// File: rtl/shift_exec_stage.sv
// Two-stage registered execute wrapper around the ALU shift path.
// Operands are captured in S1; the shifted result and zero flag are registered in S2.
module shift_exec_stage #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [N-1:0]  in_a,
    input  logic [SW-1:0] in_shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic          out_zero,
    output logic [31:0]   out_count
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic          s1_valid_r;
    logic [1:0]    s1_op_r;
    logic [N-1:0]  s1_a_r;
    logic [SW-1:0] s1_shamt_r;

    logic          s2_valid_r;
    logic [N-1:0]  result_r;
    logic          zero_r;
    logic [31:0]   count_r;

    logic          s2_free_s;
    logic          accept_s;
    logic          advance_s;
    logic          drain_s;
    logic [N-1:0]  shift_s;

    function automatic logic [N-1:0] shl_fn(input logic [N-1:0] a, input logic [SW-1:0] sh);
        return a << sh;
    endfunction

    function automatic logic [N-1:0] shr_fn(input logic [N-1:0] a, input logic [SW-1:0] sh);
        return a >> sh;
    endfunction

    function automatic logic [N-1:0] sra_fn(input logic [N-1:0] a, input logic [SW-1:0] sh);
        logic signed [N-1:0] sa;
        sa = a;
        return sa >>> sh;
    endfunction

    // Rotate by shifting a doubled copy so shamt=0 needs no special case.
    function automatic logic [N-1:0] ror_fn(input logic [N-1:0] a, input logic [SW-1:0] sh);
        logic [2*N-1:0] dbl;
        dbl = {a, a} >> sh;
        return dbl[N-1:0];
    endfunction

    assign s2_free_s  = !s2_valid_r || out_ready;
    assign in_ready   = !s1_valid_r || s2_free_s;
    assign accept_s   = in_valid && in_ready;
    assign advance_s  = s1_valid_r && s2_free_s;
    assign drain_s    = s2_valid_r && out_ready;

    assign out_valid  = s2_valid_r;
    assign out_result = result_r;
    assign out_zero   = zero_r;
    assign out_count  = count_r;

    // Select the shifter output for the op held in S1.
    always_comb begin
        shift_s = {N{1'b0}};
        case (s1_op_r)
            OP_SLL:  shift_s = shl_fn(s1_a_r, s1_shamt_r);
            OP_SRL:  shift_s = shr_fn(s1_a_r, s1_shamt_r);
            OP_SRA:  shift_s = sra_fn(s1_a_r, s1_shamt_r);
            OP_ROR:  shift_s = ror_fn(s1_a_r, s1_shamt_r);
            default: shift_s = {N{1'b0}};
        endcase
    end

    // S1 operand capture; a same-edge accept takes priority over emptying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 2'b00;
            s1_a_r     <= {N{1'b0}};
            s1_shamt_r <= {SW{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_op_r    <= in_op;
            s1_a_r     <= in_a;
            s1_shamt_r <= in_shamt;
        end else if (advance_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2 result register; value and zero flag only change when S1 advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= {N{1'b0}};
            zero_r     <= 1'b0;
        end else if (advance_s) begin
            s2_valid_r <= 1'b1;
            result_r   <= shift_s;
            zero_r     <= (shift_s == {N{1'b0}});
        end else if (drain_s) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Completed output handshakes; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (drain_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed scoreboard bench for shift_exec_stage: expected results are queued
// at input handshakes and compared at output handshakes.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [31:0] out_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt;
    logic [31:0] exp_q[$];
    logic [11:0] ov_bits;

    shift_exec_stage #(.N(32), .SW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // Bit-by-bit reference shifter.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
        logic [31:0] r;
        int s;
        s = int'(sh);
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            case (op)
                2'b00:   if (i >= s) r[i] = a[i-s]; else r[i] = 1'b0;
                2'b01:   if (i + s < 32) r[i] = a[i+s]; else r[i] = 1'b0;
                2'b10:   if (i + s < 32) r[i] = a[i+s]; else r[i] = a[31];
                default: r[i] = a[(i+s)%32];
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        logic [31:0] e;
        chk("out_count", out_count, exp_cnt);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_result", out_result, e);
                chk("out_zero", {31'd0, out_zero}, {31'd0, (e == 32'd0)});
            end
            exp_cnt = exp_cnt + 32'd1;
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_shamt));
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [4:0] sh, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_shamt  = sh;
        out_ready = ordy;
        #1;
        sample();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'b00, 32'd0, 5'd0, ordy);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 20) begin
            idle(1'b1);
            k++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 32'd0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 32'd0;
        in_shamt  = 5'd0;
        out_ready = 1'b0;
        exp_cnt   = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
        chk("rst_out_count", out_count, 32'd0);
        rst = 1'b0;

        // Latency: SLL 1 by 31
        step(1'b1, 2'b00, 32'h0000_0001, 5'd31, 1'b1);
        idle(1'b1);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_result", out_result, 32'h8000_0000);
        idle(1'b1);
        chk("lat_count", out_count, 32'd1);

        // Operator and boundary mix, streamed
        step(1'b1, 2'b01, 32'h8000_0000, 5'd31, 1'b1);
        step(1'b1, 2'b10, 32'h8000_0000, 5'd4,  1'b1);
        step(1'b1, 2'b11, 32'h0000_0001, 5'd1,  1'b1);
        step(1'b1, 2'b01, 32'h0000_000F, 5'd4,  1'b1);
        step(1'b1, 2'b00, 32'hDEAD_BEEF, 5'd0,  1'b1);
        step(1'b1, 2'b10, 32'hDEAD_BEEF, 5'd0,  1'b1);
        step(1'b1, 2'b11, 32'h1234_5678, 5'd31, 1'b1);
        step(1'b1, 2'b10, 32'h8000_0000, 5'd31, 1'b1);
        step(1'b1, 2'b10, 32'h7FFF_FFFF, 5'd31, 1'b1);
        step(1'b1, 2'b00, 32'hFFFF_FFFF, 5'd31, 1'b1);
        drain();

        // Back-to-back stream of 8 SRL ops
        do_reset();
        ov_bits = 12'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b01, 32'(i), 5'd0, 1'b1);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            ov_bits[i] = out_valid;
        end
        for (int i = 8; i < 12; i++) begin
            idle(1'b1);
            ov_bits[i] = out_valid;
        end
        chk("stream_out_valid_pattern", {20'd0, ov_bits}, 32'h0000_03FC);
        chk("stream_count", out_count, 32'd8);

        // Backpressure
        step(1'b1, 2'b00, 32'h10, 5'd4, 1'b0);
        step(1'b1, 2'b01, 32'h10, 5'd4, 1'b0);
        chk("bp_accept_b", {31'd0, in_ready}, 32'd1);
        idle(1'b0);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_result", out_result, 32'h100);
        step(1'b1, 2'b11, 32'hF0F0_F0F0, 5'd8, 1'b0);
        chk("bp_in_ready_low2", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_result2", out_result, 32'h100);
        idle(1'b1);
        chk("bp_first_out", out_result, 32'h100);
        idle(1'b1);
        chk("bp_second_out", out_result, 32'h1);
        drain();

        // Reset mid-flight
        step(1'b1, 2'b00, 32'h3,  5'd1, 1'b0);
        step(1'b1, 2'b01, 32'h40, 5'd2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_result", out_result, 32'd0);
        chk("async_rst_count", out_count, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        exp_cnt = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        end

        // Counter wrap
        @(negedge clk);
        force dut.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.count_r;
        exp_cnt = 32'hFFFF_FFFF;
        chk("wrap_preset", out_count, 32'hFFFF_FFFF);
        step(1'b1, 2'b00, 32'h2, 5'd1, 1'b1);
        drain();
        chk("wrap_count", out_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Registered execute-stage wrapper for the ALU shift path.
- Captures operands from the decode stage with a valid/ready handshake.
- Computes SLL, SRL, SRA or ROR through the existing combinational shifters.
- Presents the registered result to writeback: 2-cycle latency, 1 op/cycle throughput, full backpressure support.

Parameters:
- N, 32, datapath width; only 32 is supported.
- SW, 5, shift-amount width; always $clog2(N).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid op.
- in_ready  output  1  stage accepts an op this cycle.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- in_a  input  N  operand to shift.
- in_shamt  input  SW  shift amount, 0..31.
- out_valid  output  1  out_result is valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  N  shifted value.
- out_zero  output  1  out_result == 0.
- out_count  output  32  number of completed output handshakes.

Behaviour:
- Two register stages:
  - S1 holds op, a, shamt and s1_valid.
  - S2 holds result, zero and s2_valid.
- Reset (async, any time, including mid-operation): s1_valid=0, s2_valid=0, out_result=0, out_zero=0, out_count=0, all S1 fields=0. Ops in flight are dropped and never emitted.
- Handshake signals (combinational):
  - s2_free = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_free.
  - in_ready is 1 after reset.
- Accept: when in_valid && in_ready at a posedge, S1 loads in_op/in_a/in_shamt and s1_valid=1.
- Advance: when s1_valid && s2_free at a posedge, S2 loads the result of S1 and s2_valid=1. S1 clears unless a new op is accepted on the same edge.
- Drain: when out_valid && out_ready and S1 is empty, s2_valid=0.
- out_valid = s2_valid.
- out_result and out_zero hold stable while out_valid && !out_ready.
- Simultaneous accept, advance and drain on one edge is legal and required for 1 op/cycle.
- Latency: an op accepted at edge k appears with out_valid=1 after edge k+1, assuming no stall.
- Arithmetic:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: replicate a[31].
  - ROR: bits shifted out at the LSB re-enter at the MSB.
  - shamt=0 returns a unchanged for all ops.
  - shamt=31 is the boundary: SLL keeps only bit0 (in bit31); SRL yields a[31]; SRA yields all sign bits; ROR equals rotate-left by 1.
- out_zero is computed from the same value written to out_result, on the same edge.
- out_count increments by 1 on each out_valid && out_ready edge. It wraps 0xFFFFFFFF→0 with no flag.
- Ordering: results emerge strictly in acceptance order. No op is duplicated or dropped except by reset.
- Inputs are not sampled when in_ready=0. Upstream must hold them, but the stage does not depend on that.

Test Plan:
- SLL in_a=0x00000001, shamt=31, out_ready=1 → two edges later out_result=0x80000000, out_zero=0, out_count=1.
- SRL in_a=0x80000000, shamt=31 → 0x00000001; SRA in_a=0x80000000, shamt=4 → 0xF8000000; ROR in_a=0x00000001, shamt=1 → 0x80000000; SRL in_a=0x0000000F, shamt=4 → 0x00000000 with out_zero=1.
- Back-to-back stream of 8 SRL ops (in_a=i, shamt=0) with out_ready=1 → out_valid high 8 consecutive cycles, results 0..7 in order, in_ready never low, out_count=8.
- Backpressure: out_ready=0, issue ops A=0x10 SLL 4 then B=0x10 SRL 4 → in_ready=0 once both are held. out_result stays 0x100 while stalled. Raising out_ready yields 0x100 then 0x1, in order.
- Reset mid-flight: accept op, assert rst before it emerges → out_valid=0, out_result=0, out_count=0 immediately (async); op never appears after rst release.
- Counter wrap: preset out_count via 2^32 handshakes (or a force in the bench) to 0xFFFFFFFF, complete one op → out_count=0.
